// File: rtl/pic_bus_if.sv
// pic_bus_if: CPU-side bus of the interrupt controller command sequencer
interface pic_bus_if;
  logic cs_n;
  logic wr_n;
  logic rd_n;
  logic a0;
  logic [7:0] din;
  logic [7:0] dout;
  logic dout_en;
  modport master(output cs_n, wr_n, rd_n, a0, din, input dout, dout_en);
  modport slave(input cs_n, wr_n, rd_n, a0, din, output dout, dout_en);
endinterface

// File: rtl/pic_cmd_sequencer.sv
// pic_cmd_sequencer: ICW/OCW decode, mask/mode registers and status readback for the interrupt controller
module pic_cmd_sequencer #(
  parameter int NUM_IR = 8,
  parameter int LVL_W = (NUM_IR > 2) ? $clog2(NUM_IR) : 1,
  parameter int VEC_HI_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  pic_bus_if.slave            bus,
  input  logic [NUM_IR-1:0]   irr,
  input  logic [NUM_IR-1:0]   isr,
  input  logic                int_pend,
  input  logic [LVL_W-1:0]    int_lvl,
  output logic [NUM_IR-1:0]   imr,
  output logic [VEC_HI_W-1:0] vec_base,
  output logic                sngl,
  output logic                ltim,
  output logic                aeoi,
  output logic [7:0]          cas_cfg,
  output logic                init_done,
  output logic                edge_clr,
  output logic                ocw2_stb,
  output logic [2:0]          ocw2_cmd,
  output logic [LVL_W-1:0]    ocw2_lvl,
  output logic                smm
);
  typedef enum logic [2:0] {WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;
  state_t state;
  logic cs_n_q, wr_n_q, rd_n_q, a0_q, ic4, rsel, poll, poll_hit;
  logic commit, icw1, rd_act, rd_end;
  logic [7:0] din_q, rdata;
  // Decode write commit, read activity and the read data mux
  always_comb begin
    commit = !wr_n_q && bus.wr_n && !cs_n_q;
    icw1 = commit && !a0_q && din_q[4];
    rd_act = !bus.rd_n && !bus.cs_n;
    rd_end = !rd_n_q && bus.rd_n && !cs_n_q;
    rdata = bus.a0 ? 8'(imr) : poll ? {int_pend, 4'b0, 3'(int_lvl)} : 8'(rsel ? isr : irr);
  end
  // Sample bus strobes; address and data are held alongside the write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      rd_n_q <= 1'b1;
      a0_q <= 1'b0;
      din_q <= '0;
    end else begin
      cs_n_q <= bus.cs_n;
      wr_n_q <= bus.wr_n;
      rd_n_q <= bus.rd_n;
      a0_q <= bus.a0;
      din_q <= bus.din;
    end
  end
  // Initialisation FSM, command registers, pulses and registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_ICW1;
      imr <= '0;
      vec_base <= '0;
      sngl <= 1'b0;
      ltim <= 1'b0;
      aeoi <= 1'b0;
      cas_cfg <= '0;
      init_done <= 1'b0;
      edge_clr <= 1'b0;
      ocw2_stb <= 1'b0;
      ocw2_cmd <= '0;
      ocw2_lvl <= '0;
      smm <= 1'b0;
      ic4 <= 1'b0;
      rsel <= 1'b0;
      poll <= 1'b0;
      poll_hit <= 1'b0;
      bus.dout <= '0;
      bus.dout_en <= 1'b0;
    end else begin
      edge_clr <= 1'b0;
      ocw2_stb <= 1'b0;
      bus.dout_en <= rd_act && !commit;
      bus.dout <= (rd_act && !commit) ? rdata : 8'h00;
      poll_hit <= rd_act && poll && !bus.a0;
      if (rd_end && poll_hit) poll <= 1'b0;
      if (icw1) begin
        state <= WAIT_ICW2;
        imr <= '0;
        smm <= 1'b0;
        aeoi <= 1'b0;
        cas_cfg <= '0;
        init_done <= 1'b0;
        poll <= 1'b0;
        rsel <= 1'b0;
        edge_clr <= 1'b1;
        ic4 <= din_q[0];
        sngl <= din_q[1];
        ltim <= din_q[3];
      end else if (commit && a0_q) begin
        case (state)
          WAIT_ICW2: begin
            vec_base <= din_q[7 -: VEC_HI_W];
            state <= !sngl ? WAIT_ICW3 : ic4 ? WAIT_ICW4 : READY;
            init_done <= sngl && !ic4;
          end
          WAIT_ICW3: begin
            cas_cfg <= din_q;
            state <= ic4 ? WAIT_ICW4 : READY;
            init_done <= !ic4;
          end
          WAIT_ICW4: begin
            aeoi <= din_q[1];
            state <= READY;
            init_done <= 1'b1;
          end
          READY: imr <= din_q[NUM_IR-1:0];
          default: ;
        endcase
      end else if (commit && state == READY && !din_q[3]) begin
        ocw2_stb <= 1'b1;
        ocw2_cmd <= din_q[7:5];
        ocw2_lvl <= din_q[LVL_W-1:0];
      end else if (commit && state == READY) begin
        if (din_q[2]) poll <= 1'b1;
        if (din_q[1]) rsel <= din_q[0];
        if (din_q[6]) smm <= din_q[5];
      end
    end
  end
endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// tb_pic_cmd_sequencer: directed checks of the command sequencer in 8-line and 4-line builds
module tb_pic_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0;
  logic [7:0] din = '0, irr = '0, isr = '0;
  logic int_pend = 1'b0;
  logic [2:0] int_lvl = '0;
  int checks = 0, failures = 0;
  logic [7:0] rd8, rd4;
  logic en8, en4;
  logic [7:0] imr8, cas8, cas4;
  logic [3:0] imr4;
  logic [4:0] vb8, vb4;
  logic sngl8, ltim8, aeoi8, id8, ec8, stb8, smm8;
  logic sngl4, ltim4, aeoi4, id4, ec4, stb4, smm4;
  logic [2:0] cmd8, cmd4, lvl8;
  logic [1:0] lvl4;
  pic_bus_if b8();
  pic_bus_if b4();
  assign {b8.cs_n, b8.wr_n, b8.rd_n, b8.a0, b8.din} = {cs_n, wr_n, rd_n, a0, din};
  assign {b4.cs_n, b4.wr_n, b4.rd_n, b4.a0, b4.din} = {cs_n, wr_n, rd_n, a0, din};
  always #5 clk = ~clk;
  pic_cmd_sequencer dut (.clk(clk), .rst(rst), .bus(b8), .irr(irr), .isr(isr),
    .int_pend(int_pend), .int_lvl(int_lvl), .imr(imr8), .vec_base(vb8), .sngl(sngl8),
    .ltim(ltim8), .aeoi(aeoi8), .cas_cfg(cas8), .init_done(id8), .edge_clr(ec8),
    .ocw2_stb(stb8), .ocw2_cmd(cmd8), .ocw2_lvl(lvl8), .smm(smm8));
  pic_cmd_sequencer #(.NUM_IR(4), .LVL_W(2)) dut4 (.clk(clk), .rst(rst), .bus(b4),
    .irr(irr[3:0]), .isr(isr[3:0]), .int_pend(int_pend), .int_lvl(int_lvl[1:0]),
    .imr(imr4), .vec_base(vb4), .sngl(sngl4), .ltim(ltim4), .aeoi(aeoi4), .cas_cfg(cas4),
    .init_done(id4), .edge_clr(ec4), .ocw2_stb(stb4), .ocw2_cmd(cmd4), .ocw2_lvl(lvl4),
    .smm(smm4));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic a, input logic [7:0] d);
    @(negedge clk) cs_n = 1'b0; a0 = a; din = d; wr_n = 1'b0;
    @(negedge clk) wr_n = 1'b1;
    @(negedge clk) cs_n = 1'b1;
  endtask
  task automatic rd(input logic a);
    @(negedge clk) cs_n = 1'b0; a0 = a; rd_n = 1'b0;
    @(negedge clk) {rd8, en8, rd4, en4} = {b8.dout, b8.dout_en, b4.dout, b4.dout_en}; rd_n = 1'b1;
    @(negedge clk) cs_n = 1'b1;
  endtask
  task automatic do_rst();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_init_done", id8, 0);
    chk("rst_imr", imr8, 0);
    chk("rst_dout_en", b8.dout_en, 0);
    chk("rst_ocw2_cmd", cmd8, 0);
    wr(1'b1, 8'hFF);
    chk("imr_locked_wait_icw1", imr8, 0);
    wr(1'b0, 8'h13);
    chk("t1_edge_clr", ec8, 1);
    chk("t1_sngl", sngl8, 1);
    @(negedge clk) chk("t1_edge_clr_drop", ec8, 0);
    wr(1'b1, 8'h48);
    chk("t1_vec_base", vb8, 5'b01001);
    chk("t1_not_done", id8, 0);
    wr(1'b1, 8'h03);
    chk("t1_aeoi", aeoi8, 1);
    chk("t1_no_icw3", cas8, 0);
    chk("t1_init_done", id8, 1);
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h48);
    wr(1'b0, 8'h20);
    chk("t2_a0_0_ignored", stb8, 0);
    wr(1'b1, 8'h04);
    wr(1'b1, 8'h01);
    chk("t2_cas_cfg", cas8, 8'h04);
    chk("t2_aeoi", aeoi8, 0);
    chk("t2_init_done", id8, 1);
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h48);
    wr(1'b1, 8'h04);
    wr(1'b0, 8'h11);
    chk("t2_reicw1_edge_clr", ec8, 1);
    chk("t2_reicw1_cas_cfg", cas8, 0);
    chk("t2_reicw1_not_done", id8, 0);
    @(negedge clk) chk("t2_edge_clr_once", ec8, 0);
    wr(1'b1, 8'h50);
    chk("t2_back_in_icw2", vb8, 5'h0A);
    wr(1'b1, 8'h02);
    chk("t2_icw3_again", cas8, 8'h02);
    wr(1'b1, 8'h00);
    chk("t2_ready_again", id8, 1);
    wr(1'b1, 8'hA5);
    chk("t3_imr", imr8, 8'hA5);
    chk("t3_dout_en_idle", b8.dout_en, 0);
    rd(1'b1);
    chk("t3_rd_imr", rd8, 8'hA5);
    chk("t3_rd_en", en8, 1);
    chk("t3_en_dropped", b8.dout_en, 0);
    irr = 8'h11;
    isr = 8'h04;
    wr(1'b0, 8'h0B);
    rd(1'b0);
    chk("t4_rd_isr", rd8, 8'h04);
    wr(1'b0, 8'h0A);
    rd(1'b0);
    chk("t4_rd_irr", rd8, 8'h11);
    int_pend = 1'b1;
    int_lvl = 3'd5;
    wr(1'b0, 8'h0C);
    rd(1'b0);
    chk("t5_poll", rd8, 8'h85);
    rd(1'b0);
    chk("t5_poll_disarmed", rd8, 8'h11);
    wr(1'b0, 8'h0C);
    rd(1'b1);
    chk("t5_poll_a0_imr", rd8, 8'hA5);
    rd(1'b0);
    chk("t5_poll_kept", rd8, 8'h85);
    rd(1'b0);
    chk("t5_poll_gone", rd8, 8'h11);
    wr(1'b0, 8'h65);
    chk("t5_ocw2_stb", stb8, 1);
    chk("t5_ocw2_cmd", cmd8, 3'b011);
    chk("t5_ocw2_lvl", lvl8, 3'd5);
    @(negedge clk) chk("t5_ocw2_stb_drop", stb8, 0);
    wr(1'b0, 8'h68);
    chk("t5_smm", smm8, 1);
    do_rst();
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h48);
    wr(1'b1, 8'h04);
    wr(1'b1, 8'h01);
    chk("t6_done4", id4, 1);
    wr(1'b1, 8'hFF);
    chk("t6_imr4", imr4, 4'hF);
    rd(1'b1);
    chk("t6_rd_imr4", rd4, 8'h0F);
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h48);
    do_rst();
    chk("t6_rst_init_done", id4, 0);
    chk("t6_rst_imr", imr4, 0);
    chk("t6_rst_vec_base", vb4, 0);
    wr(1'b1, 8'h33);
    chk("t6_wait_icw1_imr", imr4, 0);
    chk("t6_wait_icw1_vec", vb4, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
